// File: rtl/bip_pkg.sv
// Shared definitions for the BIP accumulator datapath: opcodes, source-select
// codes and the serial multiplier state encoding.
package bip_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SAR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    localparam logic [1:0] SELA_MEM  = 2'b00;
    localparam logic [1:0] SELA_OPER = 2'b01;
    localparam logic [1:0] SELA_ALU  = 2'b10;
    localparam logic [1:0] SELA_HOLD = 2'b11;

    localparam logic SELB_MEM  = 1'b0;
    localparam logic SELB_OPER = 1'b1;

    typedef enum logic [0:0] {
        MUL_IDLE = 1'b0,
        MUL_RUN  = 1'b1
    } mul_state_e;

endpackage

// File: rtl/bip_mul_serial.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle over NB_DATA cycles.
// o_last/o_result/o_high_nz describe the final step so the caller can write it on that edge.
module bip_mul_serial
    import bip_pkg::*;
#(
    parameter int NB_DATA = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_a,
    input  logic [NB_DATA-1:0] i_b,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_last,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_high_nz
);

    localparam int NB_CNT = $clog2(NB_DATA + 1);
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NB_DATA - 1);

    mul_state_e               state_r;
    mul_state_e               state_nxt_s;
    logic [NB_CNT-1:0]        count_r;
    logic [2*NB_DATA-1:0]     mcand_r;
    logic [NB_DATA-1:0]       mplier_r;
    logic [2*NB_DATA-1:0]     prod_r;
    logic [2*NB_DATA-1:0]     prod_step_s;
    logic                     done_r;
    logic                     last_s;

    assign prod_step_s = prod_r + (mplier_r[0] ? mcand_r : {(2*NB_DATA){1'b0}});
    assign last_s      = (state_r == MUL_RUN) && (count_r == CNT_LAST);

    assign o_busy    = (state_r == MUL_RUN);
    assign o_done    = done_r;
    assign o_last    = last_s;
    assign o_result  = prod_step_s[NB_DATA-1:0];
    assign o_high_nz = |prod_step_s[2*NB_DATA-1:NB_DATA];

    // Multiply FSM state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r <= MUL_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Multiply FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            MUL_IDLE: begin
                if (i_start) begin
                    state_nxt_s = MUL_RUN;
                end else begin
                    state_nxt_s = MUL_IDLE;
                end
            end
            MUL_RUN: begin
                if (last_s) begin
                    state_nxt_s = MUL_IDLE;
                end else begin
                    state_nxt_s = MUL_RUN;
                end
            end
            default: state_nxt_s = MUL_IDLE;
        endcase
    end

    // Operand latch, partial-product accumulation and iteration counter
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_r  <= {NB_CNT{1'b0}};
            mcand_r  <= {(2*NB_DATA){1'b0}};
            mplier_r <= {NB_DATA{1'b0}};
            prod_r   <= {(2*NB_DATA){1'b0}};
            done_r   <= 1'b0;
        end else begin
            done_r <= last_s;
            if ((state_r == MUL_IDLE) && i_start) begin
                mcand_r  <= {{NB_DATA{1'b0}}, i_a};
                mplier_r <= i_b;
                prod_r   <= {(2*NB_DATA){1'b0}};
                count_r  <= {NB_CNT{1'b0}};
            end else if (state_r == MUL_RUN) begin
                prod_r   <= prod_step_s;
                mcand_r  <= {mcand_r[2*NB_DATA-2:0], 1'b0};
                mplier_r <= {1'b0, mplier_r[NB_DATA-1:1]};
                count_r  <= last_s ? {NB_CNT{1'b0}} : count_r + NB_CNT'(1);
            end
        end
    end

endmodule

// File: rtl/bip_datapath_ext.sv
// BIP accumulator datapath with extended ALU and registered status flags.
// Define BIP_DATAPATH_MUL_EN to build the iterative multiplier for opcode 7.
module bip_datapath_ext
    import bip_pkg::*;
#(
    parameter int NB_DATA    = 16,
    parameter int NB_OPERAND = 11,
    parameter int NB_OP      = 3
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [1:0]            i_selA,
    input  logic                  i_selB,
    input  logic                  i_WrAcc,
    input  logic [NB_OP-1:0]      i_Op,
    input  logic [NB_OPERAND-1:0] i_Operand,
    input  logic [NB_DATA-1:0]    i_data_memory,
    output logic [NB_OPERAND-1:0] o_Addr,
    output logic [NB_DATA-1:0]    o_data_memory,
    output logic                  o_zero,
    output logic                  o_neg,
    output logic                  o_carry,
    output logic                  o_overflow,
    output logic                  o_busy,
    output logic                  o_done
);

    logic [NB_DATA-1:0] acc_r;
    logic               zero_r;
    logic               neg_r;
    logic               carry_r;
    logic               ovf_r;

    logic [NB_DATA-1:0] oper_ext_s;
    logic [NB_DATA-1:0] b_s;
    logic [NB_DATA:0]   sum_s;
    logic [NB_DATA:0]   diff_s;
    logic [NB_DATA-1:0] alu_res_s;
    logic               alu_carry_s;
    logic               alu_ovf_s;

    logic               wr_en_s;
    logic               acc_we_s;
    logic [NB_DATA-1:0] acc_nxt_s;
    logic               carry_nxt_s;
    logic               ovf_nxt_s;

    logic               mul_busy_s;
    logic               mul_done_s;
    logic               mul_last_s;
    logic [NB_DATA-1:0] mul_res_s;
    logic               mul_high_nz_s;

    generate
        if (NB_DATA > NB_OPERAND) begin : g_sext
            assign oper_ext_s = {{(NB_DATA-NB_OPERAND){i_Operand[NB_OPERAND-1]}}, i_Operand};
        end else begin : g_nosext
            assign oper_ext_s = i_Operand;
        end
    endgenerate

    assign b_s    = (i_selB == SELB_OPER) ? oper_ext_s : i_data_memory;
    assign sum_s  = {1'b0, acc_r} + {1'b0, b_s};
    assign diff_s = {1'b0, acc_r} - {1'b0, b_s};

    // The multiplier owns the datapath while busy, so every other write is gated off.
    assign wr_en_s = i_WrAcc && !mul_busy_s && (i_selA != SELA_HOLD);

`ifdef BIP_DATAPATH_MUL_EN
    logic mul_start_s;

    bip_mul_serial #(
        .NB_DATA (NB_DATA)
    ) u_mul (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_start   (mul_start_s),
        .i_a       (acc_r),
        .i_b       (b_s),
        .o_busy    (mul_busy_s),
        .o_done    (mul_done_s),
        .o_last    (mul_last_s),
        .o_result  (mul_res_s),
        .o_high_nz (mul_high_nz_s)
    );
`else
    assign mul_busy_s    = 1'b0;
    assign mul_done_s    = 1'b0;
    assign mul_last_s    = 1'b0;
    assign mul_res_s     = {NB_DATA{1'b0}};
    assign mul_high_nz_s = 1'b0;
`endif

    assign o_Addr        = i_Operand;
    assign o_data_memory = acc_r;
    assign o_zero        = zero_r;
    assign o_neg         = neg_r;
    assign o_carry       = carry_r;
    assign o_overflow    = ovf_r;
    assign o_busy        = mul_busy_s;
    assign o_done        = mul_done_s;

    // Single-cycle ALU: result plus carry/overflow candidates
    always_comb begin
        alu_res_s   = {NB_DATA{1'b0}};
        alu_carry_s = 1'b0;
        alu_ovf_s   = 1'b0;
        case (i_Op)
            OP_ADD: begin
                alu_res_s   = sum_s[NB_DATA-1:0];
                alu_carry_s = sum_s[NB_DATA];
                alu_ovf_s   = (acc_r[NB_DATA-1] == b_s[NB_DATA-1]) &&
                              (sum_s[NB_DATA-1] != acc_r[NB_DATA-1]);
            end
            OP_SUB: begin
                alu_res_s   = diff_s[NB_DATA-1:0];
                alu_carry_s = diff_s[NB_DATA];
                alu_ovf_s   = (acc_r[NB_DATA-1] != b_s[NB_DATA-1]) &&
                              (diff_s[NB_DATA-1] != acc_r[NB_DATA-1]);
            end
            OP_AND: alu_res_s = acc_r & b_s;
            OP_OR:  alu_res_s = acc_r | b_s;
            OP_XOR: alu_res_s = acc_r ^ b_s;
            OP_SHL: begin
                alu_res_s   = {acc_r[NB_DATA-2:0], 1'b0};
                alu_carry_s = acc_r[NB_DATA-1];
            end
            OP_SAR: begin
                alu_res_s   = {acc_r[NB_DATA-1], acc_r[NB_DATA-1:1]};
                alu_carry_s = acc_r[0];
            end
            default: begin
                alu_res_s   = {NB_DATA{1'b0}};
                alu_carry_s = 1'b0;
                alu_ovf_s   = 1'b0;
            end
        endcase
    end

    // Accumulator source selection and multiply start decode
    always_comb begin
        acc_we_s    = 1'b0;
        acc_nxt_s   = acc_r;
        carry_nxt_s = carry_r;
        ovf_nxt_s   = ovf_r;
`ifdef BIP_DATAPATH_MUL_EN
        mul_start_s = 1'b0;
`endif
        if (mul_last_s) begin
            acc_we_s    = 1'b1;
            acc_nxt_s   = mul_res_s;
            carry_nxt_s = 1'b0;
            ovf_nxt_s   = mul_high_nz_s;
        end else if (wr_en_s) begin
            case (i_selA)
                SELA_MEM: begin
                    acc_we_s  = 1'b1;
                    acc_nxt_s = i_data_memory;
                end
                SELA_OPER: begin
                    acc_we_s  = 1'b1;
                    acc_nxt_s = oper_ext_s;
                end
                SELA_ALU: begin
                    if (i_Op != OP_MUL) begin
                        acc_we_s    = 1'b1;
                        acc_nxt_s   = alu_res_s;
                        carry_nxt_s = alu_carry_s;
                        ovf_nxt_s   = alu_ovf_s;
                    end else begin
`ifdef BIP_DATAPATH_MUL_EN
                        mul_start_s = 1'b1;
`else
                        acc_we_s    = 1'b0;
`endif
                    end
                end
                default: acc_we_s = 1'b0;
            endcase
        end else begin
            acc_we_s = 1'b0;
        end
    end

    // Accumulator and status flag registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            acc_r   <= {NB_DATA{1'b0}};
            zero_r  <= 1'b0;
            neg_r   <= 1'b0;
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (acc_we_s) begin
            acc_r   <= acc_nxt_s;
            zero_r  <= (acc_nxt_s == {NB_DATA{1'b0}});
            neg_r   <= acc_nxt_s[NB_DATA-1];
            carry_r <= carry_nxt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

endmodule
